// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
// Active-low segment patterns, FSM states and a width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns written seg[6:0] (g..a), index = hex value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern.
// Ports: nibble (4-bit hex value) -> seg (seg[0]=a .. seg[6]=g).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller for common-anode 7-segment digits.
// Ports: clk, rst (async high), enable, load_data/load_dp/load_valid
// -> load_ready; seg, dp, an (all active-low), frame_done pulse.
// Option: SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = clog2(NUM_DIGITS);
  localparam int PW = clog2(REFRESH_DIV);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] SLOT_END  = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic wrap;

  logic [DW-1:0]         disp_q, pend_q;
  logic [NUM_DIGITS-1:0] disp_dp_q, pend_dp_q;
  logic pend_full_q, pend_full_d;
  logic accept, xfer;

  logic [3:0] nib;
  logic [6:0] seg_raw;
  logic drv, lz_blank;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    idx_d   = idx_q;
    wrap    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      presc_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          presc_d = '0;
        end
        BLANK: begin
          presc_d = presc_q + PW'(1);
          if (presc_q == BLANK_END) state_d = DRIVE;
        end
        DRIVE: begin
          if (presc_q == SLOT_END) begin
            presc_d = '0;
            state_d = BLANK;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Frame swaps only at a frame boundary, or at once when dark.
  assign accept = load_valid && load_ready;
  assign xfer   = pend_full_q && (wrap || state_q == IDLE);

  always_comb begin
    pend_full_d = pend_full_q;
    if (xfer) pend_full_d = 1'b0;
    if (accept) pend_full_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_q      <= '0;
      disp_dp_q   <= '0;
      pend_q      <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      if (xfer) begin
        disp_q    <= pend_q;
        disp_dp_q <= pend_dp_q;
      end
      if (accept) begin
        pend_q    <= load_data;
        pend_dp_q <= load_dp;
      end
      pend_full_q <= pend_full_d;
      load_ready  <= ~pend_full_d;
    end
  end

  assign nib = disp_q[{idx_q, 2'b00} +: 4];

  hex_to_seg7 u_dec (
    .nibble (nib),
    .seg    (seg_raw)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zmask;
  logic                  zrun;

  // zmask[k]: nibble k and every higher nibble are zero.
  always_comb begin
    zmask = '0;
    zrun  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zrun     = zrun && (disp_q[4*k +: 4] == 4'h0);
      zmask[k] = zrun;
    end
    lz_blank = zmask[idx_q] && (idx_q != '0);
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign drv = enable && (state_q == DRIVE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= drv ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg        <= (drv && !lz_blank) ? seg_raw : SEG_BLANK;
      dp         <= drv ? ~disp_dp_q[idx_q] : 1'b1;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 8-cycle slots).
// Table vectors, directed corner sequences and a random model run.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk, rst, enable, load_valid, load_ready;
  logic [4*N-1:0] load_data;
  logic [N-1:0] load_dp, an;
  logic [6:0] seg;
  logic dp, frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nvec = 0;
  int nerr = 0;

  // Reference model: scan position is a plain cycle count
  // within the frame; buffers are plain words.
  logic      m_run;
  int        m_k;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_pf;

  typedef struct {
    logic [15:0]      data;
    logic [3:0]       dpv;
    logic [3:0][6:0]  segs;
    logic [3:0]       dpn;
  } vec_t;

  vec_t tab [6];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic fail_to(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s: timeout waiting, expected event", nm);
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_k    = 0;
    m_disp = '0;
    m_pend = '0;
    m_ddp  = '0;
    m_pdp  = '0;
    m_pf   = 1'b0;
  endtask

  task automatic step();
    int d, pos;
    logic drv, wrap, acc, ed;
    logic [15:0] sh;
    logic [3:0] ea;
    logic [6:0] es;
    logic [13:0] e, a;
    d    = (m_k / RD) % N;
    pos  = m_k % RD;
    drv  = m_run && enable && pos >= BC;
    wrap = m_run && enable && pos == RD - 1 && d == N - 1;
    ea = 4'hF;
    es = 7'h7F;
    ed = 1'b1;
    if (drv) begin
      sh = m_disp >> (4 * d);
      ea = ~(4'b0001 << d);
      es = SEG_TAB[sh[3:0]];
      ed = ~m_ddp[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (d != 0 && sh == 16'h0) es = 7'h7F;
`endif
    end
    acc = load_valid && !m_pf;
    if (m_pf && (wrap || !m_run)) begin
      m_disp = m_pend;
      m_ddp  = m_pdp;
      m_pf   = 1'b0;
    end
    if (acc) begin
      m_pend = load_data;
      m_pdp  = load_dp;
      m_pf   = 1'b1;
    end
    if (!enable) begin
      m_run = 1'b0;
      m_k   = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_k   = 0;
    end else begin
      m_k = (m_k + 1) % (N * RD);
    end
    e = {ea, es, ed, wrap, !m_pf};
    @(posedge clk);
    #1;
    a = {an, seg, dp, frame_done, load_ready};
    chk("cycle", {18'h0, a}, {18'h0, e});
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    #1;
    chk("async_rst",
        {18'h0, an, seg, dp, frame_done, load_ready},
        {18'h0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic got;
    int   nfd;
    logic [6:0] cs [N];
    logic cd [N];

    tab[0] = '{16'h1A3F, 4'b0100,
      {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}, 4'b1011};
    tab[1] = '{16'h8765, 4'b1001,
      {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010}, 4'b0110};
    tab[2] = '{16'hEDCB, 4'b0000,
      {7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011}, 4'b1111};
    tab[3] = '{16'h4290, 4'b1111,
      {7'b0011001, 7'b0100100, 7'b0011000, 7'b1000000}, 4'b0000};
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    tab[4] = '{16'h0050, 4'b0010,
      {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'b1101};
    tab[5] = '{16'h0000, 4'b0000,
      {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
`else
    tab[4] = '{16'h0050, 4'b0010,
      {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}, 4'b1101};
    tab[5] = '{16'h0000, 4'b0000,
      {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
`endif

    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    rst        = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset_dut();

    // Scan with no data loaded; two frames worth of pulses.
    enable = 1'b1;
    nfd = 0;
    for (int i = 0; i < 66; i++) begin
      step();
      nfd += int'(frame_done);
    end
    chk("fd_count", nfd, 2);

    // Load mid-frame, then a second load held against a full buffer.
    load_data  = 16'h1A3F;
    load_dp    = 4'b0100;
    load_valid = 1'b1;
    step();
    chk("ready_drop", {31'h0, load_ready}, 0);
    load_data = 16'h2222;
    load_dp   = 4'b0001;
    for (int i = 0; i < 80 && !load_ready; i++) step();
    if (!load_ready) fail_to("ready_rise");
    step();
    load_valid = 1'b0;
    chk("second_accept", {31'h0, load_ready}, 0);
    for (int i = 0; i < 40; i++) step();

    // Drop enable while digit 2 is driven, then restart.
    for (int i = 0; i < 64 && an !== 4'b1011; i++) step();
    if (an !== 4'b1011) fail_to("reach_dig2");
    step();
    enable = 1'b0;
    step();
    chk("dark_an", {28'h0, an}, 32'hF);
    chk("dark_seg", {25'h0, seg}, 32'h7F);
    step();
    enable = 1'b1;
    for (int i = 0; i < 16 && an === 4'hF; i++) step();
    chk("restart_dig0", {28'h0, an}, 32'hE);

    // Reset during DRIVE with a load pending.
    for (int i = 0; i < 16 && an === 4'hF; i++) step();
    load_data  = 16'h9999;
    load_dp    = 4'hF;
    load_valid = 1'b1;
    for (int i = 0; i < 40 && !load_ready; i++) step();
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 16 && an === 4'hF; i++) step();
    reset_dut();
    for (int i = 0; i < 16 && an === 4'hF; i++) step();
    chk("post_rst_seg", {25'h0, seg}, {25'h0, 7'b1000000});
    chk("post_rst_rdy", {31'h0, load_ready}, 1);

    // Table vectors: load while dark, then capture one frame.
    for (int t = 0; t < 6; t++) begin
      enable     = 1'b0;
      load_valid = 1'b0;
      step();
      step();
      load_data  = tab[t].data;
      load_dp    = tab[t].dpv;
      load_valid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        got = load_ready;
        step();
      end
      chk($sformatf("tab%0d_accept", t), {31'h0, got}, 1);
      load_valid = 1'b0;
      step();
      step();
      enable = 1'b1;
      for (int k = 0; k < N; k++) begin
        cs[k] = 'x;
        cd[k] = 1'bx;
      end
      for (int i = 0; i < N * RD + 2; i++) begin
        step();
        for (int k = 0; k < N; k++) begin
          if (an[k] === 1'b0) begin
            cs[k] = seg;
            cd[k] = dp;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        chk($sformatf("tab%0d_dig%0d", t, k),
            {24'h0, cs[k], cd[k]},
            {24'h0, tab[t].segs[k], tab[t].dpn[k]});
      end
    end

    // Random traffic against the model.
    for (int i = 0; i < 900; i++) begin
      if (enable) begin
        if ($urandom_range(0, 59) == 0) enable = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end
      load_valid = ($urandom_range(0, 5) == 0);
      load_data  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      load_dp    = 4'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
